// File: rtl/fizzbuzz_pkg.sv
// Shared character codes and line geometry for the FizzBuzz text path
// (sequencer, chars ROM, char mux).
package fizzbuzz_pkg;
    localparam int NCHARS = 8;

    localparam logic [3:0] CH_F     = 4'd10;
    localparam logic [3:0] CH_I     = 4'd11;
    localparam logic [3:0] CH_Z     = 4'd12;
    localparam logic [3:0] CH_B     = 4'd13;
    localparam logic [3:0] CH_U     = 4'd14;
    localparam logic [3:0] CH_BLANK = 4'd15;

    // Character in slot k of a text row: "Fizz", "Buzz" or "FizzBuzz", blank elsewhere.
    function automatic logic [3:0] text_char(input int k, input logic fz, input logic bz);
        logic [3:0] c;
        int         p;
        c = CH_BLANK;
        p = fz ? k - 4 : k;
        if (fz && k >= 0 && k < 4) begin
            case (k)
                0:       c = CH_F;
                1:       c = CH_I;
                default: c = CH_Z;
            endcase
        end else if (bz && p >= 0 && p < 4) begin
            case (p)
                0:       c = CH_B;
                1:       c = CH_U;
                default: c = CH_Z;
            endcase
        end
        return c;
    endfunction
endpackage

// File: rtl/bcd_inc.sv
// Combinational NDIGITS-wide BCD increment; cout set when every digit was 9.
module bcd_inc #(
    parameter int NDIGITS = 4
) (
    input  logic [NDIGITS-1:0][3:0] d,
    output logic [NDIGITS-1:0][3:0] q,
    output logic                    cout
);
    logic [NDIGITS:0] c;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < NDIGITS; i++) begin : g_dig
        assign q[i]   = c[i] ? ((d[i] == 4'd9) ? 4'd0 : d[i] + 4'd1) : d[i];
        assign c[i+1] = c[i] & (d[i] == 4'd9);
    end

    assign cout = c[NDIGITS];
endmodule

// File: rtl/fizzbuzz_seq.sv
// FizzBuzz row source: BCD count with mod-3/mod-5 trackers, left-aligned
// formatter and registered line/isnum/led outputs.
module fizzbuzz_seq
    import fizzbuzz_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int NCH     = NCHARS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              next,
    output logic [4*NCH-1:0]  line,
    output logic              isnum,
    output logic [7:0]        led
);
    logic [NDIGITS-1:0][3:0] cnt, cnt_inc, cnt_n;
    logic [1:0]              mod3, mod3_n;
    logic [2:0]              mod5, mod5_n;
    logic                    wrap, upd;
    logic [NCH-1:0][3:0]     line_n;
    logic                    isnum_n;
    logic [7:0]              led_n;
    int                      msd;

    bcd_inc #(.NDIGITS(NDIGITS)) u_inc (
        .d    (cnt),
        .q    (cnt_inc),
        .cout (wrap)
    );

    // Reset, restart and wrap all reload the sequence at 1 through the same path,
    // so the formatter produces the row-1 outputs for every one of them.
    always_comb begin
        cnt_n  = cnt;
        mod3_n = mod3;
        mod5_n = mod5;
        upd    = 1'b0;
        if (rst || restart || (next && wrap)) begin
            cnt_n    = '0;
            cnt_n[0] = 4'd1;
            mod3_n   = 2'd1;
            mod5_n   = 3'd1;
            upd      = 1'b1;
        end else if (next) begin
            cnt_n  = cnt_inc;
            mod3_n = (mod3 == 2'd2) ? 2'd0 : mod3 + 2'd1;
            mod5_n = (mod5 == 3'd4) ? 3'd0 : mod5 + 3'd1;
            upd    = 1'b1;
        end
    end

    always_comb begin
        msd = 0;
        for (int i = 0; i < NDIGITS; i++)
            if (cnt_n[i] != 4'd0) msd = i;

        isnum_n = !((mod3_n == 2'd0) || (mod5_n == 3'd0));
        for (int k = 0; k < NCH; k++) begin
            line_n[k] = CH_BLANK;
            if (isnum_n) begin
                for (int j = 0; j < NDIGITS; j++)
                    if (k <= msd && j == msd - k) line_n[k] = cnt_n[j];
            end else begin
                line_n[k] = text_char(k, mod3_n == 2'd0, mod5_n == 3'd0);
            end
        end
    end

    if (NDIGITS > 1) begin : g_led2
        assign led_n = {cnt_n[1], cnt_n[0]};
    end else begin : g_led1
        assign led_n = {4'd0, cnt_n[0]};
    end

    always_ff @(posedge clk) begin
        if (upd) begin
            cnt   <= cnt_n;
            mod3  <= mod3_n;
            mod5  <= mod5_n;
            line  <= line_n;
            isnum <= isnum_n;
            led   <= led_n;
        end
    end
endmodule

// File: tb/tb_fizzbuzz_seq.sv
// Directed bench for fizzbuzz_seq: row table 1..15 plus multi-cycle corner sequences.
module tb_fizzbuzz_seq;
    logic        clk = 1'b0;
    logic        rst, restart, next;
    logic [31:0] line;
    logic        isnum;
    logic [7:0]  led;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] line;
        logic        isnum;
        logic [7:0]  led;
    } row_t;

    row_t rows [15];

    fizzbuzz_seq #(.NDIGITS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .next    (next),
        .line    (line),
        .isnum   (isnum),
        .led     (led)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] el, input logic ei, input logic [7:0] ed);
        checks++;
        if (line !== el || isnum !== ei || led !== ed) begin
            failures++;
            $display("FAIL %s: got line=%h isnum=%b led=%h, want line=%h isnum=%b led=%h",
                     name, line, isnum, led, el, ei, ed);
        end
    endtask

    // n consecutive next cycles; returns at a negedge with outputs settled
    task automatic adv(input int n);
        @(negedge clk) next = 1'b1;
        repeat (n) @(negedge clk);
        next = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
    endtask

    initial begin
        rows[0]  = '{32'hFFFFFFF1, 1'b1, 8'h01};
        rows[1]  = '{32'hFFFFFFF2, 1'b1, 8'h02};
        rows[2]  = '{32'hFFFFCCBA, 1'b0, 8'h03};
        rows[3]  = '{32'hFFFFFFF4, 1'b1, 8'h04};
        rows[4]  = '{32'hFFFFCCED, 1'b0, 8'h05};
        rows[5]  = '{32'hFFFFCCBA, 1'b0, 8'h06};
        rows[6]  = '{32'hFFFFFFF7, 1'b1, 8'h07};
        rows[7]  = '{32'hFFFFFFF8, 1'b1, 8'h08};
        rows[8]  = '{32'hFFFFCCBA, 1'b0, 8'h09};
        rows[9]  = '{32'hFFFFCCED, 1'b0, 8'h10};
        rows[10] = '{32'hFFFFFF11, 1'b1, 8'h11};
        rows[11] = '{32'hFFFFCCBA, 1'b0, 8'h12};
        rows[12] = '{32'hFFFFFF31, 1'b1, 8'h13};
        rows[13] = '{32'hFFFFFF41, 1'b1, 8'h14};
        rows[14] = '{32'hCCEDCCBA, 1'b0, 8'h15};

        rst = 1'b1; restart = 1'b0; next = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset", 32'hFFFFFFF1, 1'b1, 8'h01);

        // advance a little, then restart should bring row 1 back
        adv(5);
        do_restart();
        check("row1", rows[0].line, rows[0].isnum, rows[0].led);
        for (int i = 1; i < 15; i++) begin
            adv(1);
            check($sformatf("row%0d", i + 1), rows[i].line, rows[i].isnum, rows[i].led);
        end

        adv(1024 - 15);
        check("n1024", 32'hFFFF4201, 1'b1, 8'h24);
        adv(9998 - 1024);
        check("n9998", 32'hFFFF8999, 1'b1, 8'h98);
        adv(1);
        check("n9999", 32'hFFFFCCBA, 1'b0, 8'h99);
        adv(1);
        check("wrap", 32'hFFFFFFF1, 1'b1, 8'h01);
        adv(1);
        check("post_wrap", 32'hFFFFFFF2, 1'b1, 8'h02);

        // restart wins over a simultaneous next
        adv(40);
        check("n42", 32'hFFFFCCBA, 1'b0, 8'h42);
        @(negedge clk) begin restart = 1'b1; next = 1'b1; end
        @(negedge clk) begin restart = 1'b0; next = 1'b0; end
        check("restart_and_next", 32'hFFFFFFF1, 1'b1, 8'h01);

        // back-to-back next: one step per cycle
        @(negedge clk) next = 1'b1;
        @(negedge clk) check("b2b_2", 32'hFFFFFFF2, 1'b1, 8'h02);
        @(negedge clk) check("b2b_3", 32'hFFFFCCBA, 1'b0, 8'h03);
        @(negedge clk) begin check("b2b_4", 32'hFFFFFFF4, 1'b1, 8'h04); next = 1'b0; end
        repeat (1000) @(negedge clk);
        check("hold", 32'hFFFFFFF4, 1'b1, 8'h04);

        // rst beats next; next afterwards steps to 2
        adv(3);
        check("n7", 32'hFFFFFFF7, 1'b1, 8'h07);
        @(negedge clk) begin rst = 1'b1; next = 1'b1; end
        @(negedge clk) begin rst = 1'b0; next = 1'b0; end
        check("rst_and_next", 32'hFFFFFFF1, 1'b1, 8'h01);
        adv(1);
        check("after_rst", 32'hFFFFFFF2, 1'b1, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
